// File: rtl/pipelined_div_reconstructor.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_div_reconstructor
// Function : Rebuilds dividend = quotient*divisor + remainder through a
//            DIVIDEND-stage shift-add pipeline with valid/ready flow control,
//            flagging inconsistent triples and counting them (saturating).
// Revision : 1.0
// ============================================================================
module pipelined_div_reconstructor #(
    parameter int DIVIDEND = 3,
    parameter int DIVISOR  = 2,
    parameter int CNT_W    = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIVIDEND-1:0]          quotient,
    input  logic [DIVISOR-1:0]           divisor,
    input  logic [DIVISOR-1:0]           remainder,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIVIDEND-1:0]          dividend,
    output logic [DIVIDEND+DIVISOR-1:0]  product_full,
    output logic                         overflow,
    output logic                         rem_err,
    output logic [CNT_W-1:0]             err_count
);

    localparam int c_width = DIVIDEND + DIVISOR;

    logic                r_valid [1:DIVIDEND];
    logic [c_width-1:0]  r_acc   [1:DIVIDEND];
    logic [DIVIDEND-1:0] r_q     [1:DIVIDEND];
    logic [DIVISOR-1:0]  r_d     [1:DIVIDEND];
    logic                r_rerr  [1:DIVIDEND];
    logic                r_ovf;
    logic [CNT_W-1:0]    r_err_count;

    logic                w_advance;
    logic [c_width-1:0]  w_acc_next [1:DIVIDEND];
    logic                w_ovf_next;
    logic                w_rerr_in;

    assign w_advance = !r_valid[DIVIDEND] || out_ready;
    assign in_ready  = w_advance;
    assign w_rerr_in = (remainder >= divisor);

    // Stage k adds divisor<<(k-1) when quotient bit k-1 is set.
    always_comb begin
        for (int k = 1; k <= DIVIDEND; k++) begin
            w_acc_next[k] = '0;
        end
        w_acc_next[1] = c_width'(remainder)
                      + (quotient[0] ? c_width'(divisor) : c_width'(0));
        for (int k = 2; k <= DIVIDEND; k++) begin
            w_acc_next[k] = r_acc[k-1]
                          + (r_q[k-1][k-1] ? (c_width'(r_d[k-1]) << (k-1))
                                           : c_width'(0));
        end
        w_ovf_next = |w_acc_next[DIVIDEND][c_width-1:DIVIDEND];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 1; k <= DIVIDEND; k++) begin
                r_valid[k] <= 1'b0;
                r_acc[k]   <= '0;
                r_q[k]     <= '0;
                r_d[k]     <= '0;
                r_rerr[k]  <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_valid[1] <= in_valid;
            r_acc[1]   <= w_acc_next[1];
            r_q[1]     <= quotient;
            r_d[1]     <= divisor;
            r_rerr[1]  <= w_rerr_in;
            for (int k = 2; k <= DIVIDEND; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_acc[k]   <= w_acc_next[k];
                r_q[k]     <= r_q[k-1];
                r_d[k]     <= r_d[k-1];
                r_rerr[k]  <= r_rerr[k-1];
            end
            // Overflow is registered alongside the final stage.
            r_ovf <= w_ovf_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (r_valid[DIVIDEND] && out_ready && (r_ovf || r_rerr[DIVIDEND])
                     && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid    = r_valid[DIVIDEND];
    assign product_full = r_acc[DIVIDEND];
    assign dividend     = r_acc[DIVIDEND][DIVIDEND-1:0];
    assign overflow     = r_ovf;
    assign rem_err      = r_rerr[DIVIDEND];
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_div_reconstructor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_div_reconstructor
// Function : Self-checking bench for pipelined_div_reconstructor.
// Revision : 1.0
// ============================================================================
module tb_pipelined_div_reconstructor;

    localparam int DIVIDEND = 3;
    localparam int DIVISOR  = 2;
    localparam int CNT_W    = 8;

    logic                        clock;
    logic                        reset_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [DIVIDEND-1:0]         quotient;
    logic [DIVISOR-1:0]          divisor;
    logic [DIVISOR-1:0]          remainder;
    logic                        out_valid;
    logic                        out_ready;
    logic [DIVIDEND-1:0]         dividend;
    logic [DIVIDEND+DIVISOR-1:0] product_full;
    logic                        overflow;
    logic                        rem_err;
    logic [CNT_W-1:0]            err_count;

    pipelined_div_reconstructor #(
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .CNT_W    (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .quotient     (quotient),
        .divisor      (divisor),
        .remainder    (remainder),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dividend     (dividend),
        .product_full (product_full),
        .overflow     (overflow),
        .rem_err      (rem_err),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] q;
        logic [1:0] d;
        logic [1:0] r;
        logic [4:0] full;
        logic       ovf;
        logic       rerr;
    } vec_t;

    int tests;
    int fails;
    int exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic send_vec(input vec_t v, input int id);
        int lat;
        quotient  = v.q;
        divisor   = v.d;
        remainder = v.r;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check($sformatf("v%0d_in_ready", id), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check($sformatf("v%0d_latency", id), 32'(lat), 32'(DIVIDEND - 1));
        check($sformatf("v%0d_dividend", id), 32'(dividend), 32'(v.full[2:0]));
        check($sformatf("v%0d_product_full", id), 32'(product_full), 32'(v.full));
        check($sformatf("v%0d_overflow", id), 32'(overflow), 32'(v.ovf));
        check($sformatf("v%0d_rem_err", id), 32'(rem_err), 32'(v.rerr));
        tick();
        if ((v.ovf || v.rerr) && exp_cnt < 255) exp_cnt++;
        check($sformatf("v%0d_err_count", id), 32'(err_count), 32'(exp_cnt));
        check($sformatf("v%0d_drained", id), 32'(out_valid), 32'd0);
    endtask

    vec_t       vecs [8];
    logic [2:0] sq [3];
    logic [1:0] sd [3];
    logic [1:0] sr [3];
    logic [4:0] sexp [3];
    logic [2:0] lq [32];
    logic [1:0] ld [32];
    logic [1:0] lr [32];
    logic [2:0] ln [32];
    int         lcount;
    int         got;
    int         wait_cnt;

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{q: 3'd5, d: 2'd1, r: 2'd0, full: 5'd5,  ovf: 1'b0, rerr: 1'b0};
        vecs[1] = '{q: 3'd7, d: 2'd3, r: 2'd2, full: 5'd23, ovf: 1'b1, rerr: 1'b0};
        vecs[2] = '{q: 3'd4, d: 2'd0, r: 2'd0, full: 5'd0,  ovf: 1'b0, rerr: 1'b1};
        vecs[3] = '{q: 3'd3, d: 2'd2, r: 2'd1, full: 5'd7,  ovf: 1'b0, rerr: 1'b0};
        vecs[4] = '{q: 3'd2, d: 2'd3, r: 2'd2, full: 5'd8,  ovf: 1'b1, rerr: 1'b0};
        vecs[5] = '{q: 3'd6, d: 2'd2, r: 2'd3, full: 5'd15, ovf: 1'b1, rerr: 1'b1};
        vecs[6] = '{q: 3'd0, d: 2'd3, r: 2'd3, full: 5'd3,  ovf: 1'b0, rerr: 1'b1};
        vecs[7] = '{q: 3'd7, d: 2'd1, r: 2'd0, full: 5'd7,  ovf: 1'b0, rerr: 1'b0};
        sq   = '{3'd3, 3'd2, 3'd1};
        sd   = '{2'd2, 2'd3, 2'd1};
        sr   = '{2'd1, 2'd2, 2'd0};
        sexp = '{5'd7, 5'd8, 5'd1};

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_product_full", 32'(product_full), 32'd0);
        check("rst_flags", 32'({overflow, rem_err}), 32'd0);

        // Table-driven single triples
        for (int i = 0; i < 8; i++) send_vec(vecs[i], i);

        // Back-to-back stream
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    quotient  = sq[i];
                    divisor   = sd[i];
                    remainder = sr[i];
                    in_valid  = 1'b1;
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                wait_cnt = 0;
                while (!out_valid && wait_cnt < 10) begin
                    tick();
                    wait_cnt++;
                end
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
                    check($sformatf("stream%0d_full", i), 32'(product_full), 32'(sexp[i]));
                    if (i == 2) check("stream_mid_err_count", 32'(err_count), 32'(exp_cnt + 1));
                    tick();
                end
            end
        join
        exp_cnt++;
        check("stream_err_count", 32'(err_count), 32'(exp_cnt));
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: A,B,C fill the pipe, D waits at the input
        out_ready = 1'b0;
        divisor   = 2'd1;
        remainder = 2'd0;
        in_valid  = 1'b1;
        quotient  = 3'd1;
        tick();
        quotient  = 3'd2;
        tick();
        quotient  = 3'd3;
        tick();
        quotient  = 3'd4;
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_stall%0d_full", i), 32'(product_full), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("bp_out%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_out%0d_full", i), 32'(product_full), 32'(i));
            tick();
        end
        check("bp_drained", 32'(out_valid), 32'd0);

        // Saturation of the error counter
        quotient  = 3'd0;
        divisor   = 2'd0;
        remainder = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("sat_err_count", 32'(err_count), 32'(exp_cnt));

        // Reset with two triples in flight
        quotient  = 3'd7;
        divisor   = 2'd3;
        remainder = 2'd2;
        in_valid  = 1'b1;
        tick();
        quotient  = 3'd4;
        divisor   = 2'd0;
        remainder = 2'd0;
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("midrst_no_stale%0d", i), 32'(out_valid), 32'd0);
        end

        // Loop-back sweep of every {divisor,dividend} pair with divisor != 0
        lcount = 0;
        for (int p = 0; p < 32; p++) begin
            int dv;
            int nv;
            dv = p / 8;
            nv = p % 8;
            if (dv != 0) begin
                lq[lcount] = 3'(nv / dv);
                lr[lcount] = 2'(nv % dv);
                ld[lcount] = 2'(dv);
                ln[lcount] = 3'(nv);
                lcount++;
            end
        end
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < lcount; i++) begin
                    quotient  = lq[i];
                    divisor   = ld[i];
                    remainder = lr[i];
                    in_valid  = 1'b1;
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                got      = 0;
                wait_cnt = 0;
                while (got < lcount && wait_cnt < 100) begin
                    tick();
                    wait_cnt++;
                    if (out_valid) begin
                        check($sformatf("loop%0d_dividend", got), 32'(dividend), 32'(ln[got]));
                        check($sformatf("loop%0d_flags", got), 32'({overflow, rem_err}), 32'd0);
                        got++;
                    end
                end
            end
        join
        check("loop_count", 32'(got), 32'(lcount));
        tick();
        check("loop_err_count", 32'(err_count), 32'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
